// File: rtl/dmem_pkg.sv
// Shared definitions for the CortexM0 data-side SRAM bridge: access size
// encodings, byte-enable generation, store lane replication and the
// misalignment rule.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } dsize_e;

    localparam int LANES = 4;

    // Byte lanes touched by an access of the given size at the given offset.
    function automatic logic [3:0] byte_en(input dsize_e size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Store data replicated so that every lane selected by byte_en carries it.
    function automatic logic [31:0] lane_data(input dsize_e size, input logic [31:0] data);
        logic [31:0] lanes;
        case (size)
            SZ_BYTE: lanes = {4{data[7:0]}};
            SZ_HALF: lanes = {2{data[15:0]}};
            default: lanes = data;
        endcase
        return lanes;
    endfunction

    // Halfwords must be 2-byte aligned, words 4-byte aligned; size 11 never valid.
    function automatic logic misaligned(input dsize_e size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_wbuf.sv
// One-entry posted write buffer for the data bridge.
// Build option: DMEM_WBUF_EN. When defined, writes are captured here and
// drained on the next cycle that carries no read; reads to the buffered word
// get the buffered bytes forwarded. When undefined, the block is a
// pass-through that presents the incoming write as the entry to drain in
// the same cycle, so the bridge's SRAM mux is identical in both builds.
module dmem_wbuf
    import dmem_pkg::*;
#(
    parameter int AW = 12
) (
`ifdef DMEM_WBUF_EN
    input  logic          clk,
    input  logic          rst_n,
`endif
    input  logic          wr_req,
    input  logic          rd_req,
    input  logic [AW-1:0] req_addr,
    input  logic [3:0]    req_be,
    input  logic [31:0]   req_data,
    output logic          drain,
    output logic          empty,
    output logic [AW-1:0] ent_addr,
    output logic [3:0]    ent_be,
    output logic [31:0]   ent_data,
    output logic [3:0]    fwd_mask,
    output logic [31:0]   fwd_data
);

`ifdef DMEM_WBUF_EN
    logic valid;

    // A read owns the SRAM port; otherwise a held entry goes out, either on
    // its own or alongside the capture of the next write.
    assign drain = valid && !rd_req;
    assign empty = !valid;

    // Buffered bytes override SRAM bytes for a read of the same word.
    assign fwd_mask = (valid && rd_req && (ent_addr == req_addr)) ? ent_be : 4'b0000;
    assign fwd_data = ent_data;

    // Capture a new write (replacing the entry being drained this cycle),
    // or go empty once the entry has been drained.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            ent_addr <= '0;
            ent_be   <= 4'b0000;
            ent_data <= 32'h0;
        end else if (wr_req) begin
            valid    <= 1'b1;
            ent_addr <= req_addr;
            ent_be   <= req_be;
            ent_data <= req_data;
        end else if (drain) begin
            valid    <= 1'b0;
        end
    end
`else
    // Unbuffered: the write itself is the thing to send this cycle.
    assign drain    = wr_req && !rd_req;
    assign empty    = 1'b1;
    assign ent_addr = req_addr;
    assign ent_be   = req_be;
    assign ent_data = req_data;
    assign fwd_mask = 4'b0000;
    assign fwd_data = 32'h0;
`endif

endmodule

// File: rtl/dmem_bridge.sv
// Data-side bridge between the CortexM0 data port and SRAM port 2.
// Generates byte enables and lane-replicated store data, right-aligns and
// zero-extends load data, flags misaligned/illegal accesses with a sticky
// fault, and never stalls the core.
// Build option: DMEM_WBUF_EN adds a one-entry posted write buffer with
// store-to-load forwarding (see dmem_wbuf); without it, writes reach the
// SRAM combinationally in their request cycle.
module dmem_bridge
    import dmem_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          DREQ,
    input  logic [31:0]   DADDR,
    input  logic          DRW,
    input  logic [1:0]    DSIZE,
    input  logic [31:0]   DOUT,
    output logic [31:0]   DIN,
    output logic          MCSN,
    output logic [AW-1:0] MADDR,
    output logic          MWE,
    output logic [3:0]    MBE,
    output logic [31:0]   MDI,
    input  logic [31:0]   MDO,
    output logic          FAULT,
    output logic [31:0]   FAULT_ADDR,
    input  logic          FAULT_CLR,
    output logic          WBUF_EMPTY
);

    dsize_e        dsize;
    logic          req_mis;
    logic          acc_rd;
    logic          acc_wr;
    logic [AW-1:0] word_addr;
    logic [3:0]    req_be;
    logic [31:0]   req_lanes;

    logic          wb_drain;
    logic          wb_empty;
    logic [AW-1:0] wb_addr;
    logic [3:0]    wb_be;
    logic [31:0]   wb_data;
    logic [3:0]    fwd_mask;
    logic [31:0]   fwd_data;

    logic          rd_pend;
    dsize_e        rd_size;
    logic [1:0]    rd_off;
    logic [3:0]    rd_fmask;
    logic [31:0]   rd_fdata;

    assign dsize     = dsize_e'(DSIZE);
    assign req_mis   = DREQ && misaligned(dsize, DADDR[1:0]);
    // Faulting accesses and anything during reset never reach SRAM or buffer.
    assign acc_rd    = RESET_N && DREQ && !req_mis && !DRW;
    assign acc_wr    = RESET_N && DREQ && !req_mis && DRW;
    assign word_addr = DADDR[AW+1:2];
    assign req_be    = byte_en(dsize, DADDR[1:0]);
    assign req_lanes = lane_data(dsize, DOUT);

    dmem_wbuf #(
        .AW       (AW)
    ) u_wbuf (
`ifdef DMEM_WBUF_EN
        .clk      (CLK),
        .rst_n    (RESET_N),
`endif
        .wr_req   (acc_wr),
        .rd_req   (acc_rd),
        .req_addr (word_addr),
        .req_be   (req_be),
        .req_data (req_lanes),
        .drain    (wb_drain),
        .empty    (wb_empty),
        .ent_addr (wb_addr),
        .ent_be   (wb_be),
        .ent_data (wb_data),
        .fwd_mask (fwd_mask),
        .fwd_data (fwd_data)
    );

    assign WBUF_EMPTY = wb_empty;

    // SRAM port: a read has priority, else a write goes out, else idle.
    always_comb begin
        MCSN  = 1'b1;
        MWE   = 1'b0;
        MADDR = '0;
        MBE   = 4'b0000;
        MDI   = 32'h0;
        if (acc_rd) begin
            MCSN  = 1'b0;
            MADDR = word_addr;
            MBE   = req_be;
        end else if (wb_drain && RESET_N) begin
            MCSN  = 1'b0;
            MWE   = 1'b1;
            MADDR = wb_addr;
            MBE   = wb_be;
            MDI   = wb_data;
        end
    end

    // Remember what the response cycle needs to shape the SRAM read data.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            rd_pend  <= 1'b0;
            rd_size  <= SZ_BYTE;
            rd_off   <= 2'b00;
            rd_fmask <= 4'b0000;
            rd_fdata <= 32'h0;
        end else begin
            rd_pend <= acc_rd;
            if (acc_rd) begin
                rd_size  <= dsize;
                rd_off   <= DADDR[1:0];
                rd_fmask <= fwd_mask;
                rd_fdata <= fwd_data;
            end
        end
    end

    // Response: merge forwarded bytes over MDO, right-align, zero-extend.
    always_comb begin
        logic [31:0] merged;
        logic [31:0] shifted;
        logic [31:0] aligned;
        merged = MDO;
        for (int i = 0; i < LANES; i++) begin
            if (rd_fmask[i]) begin
                merged[8*i +: 8] = rd_fdata[8*i +: 8];
            end
        end
        shifted = merged >> {rd_off, 3'b000};
        case (rd_size)
            SZ_BYTE: aligned = {24'h0, shifted[7:0]};
            SZ_HALF: aligned = {16'h0, shifted[15:0]};
            default: aligned = shifted;
        endcase
        DIN = rd_pend ? aligned : 32'h0;
    end

    // Sticky fault: a new fault beats a simultaneous clear and recaptures.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            FAULT      <= 1'b0;
            FAULT_ADDR <= 32'h0;
        end else if (req_mis) begin
            FAULT <= 1'b1;
            if (!FAULT || FAULT_CLR) begin
                FAULT_ADDR <= DADDR;
            end
        end else if (FAULT_CLR) begin
            FAULT      <= 1'b0;
            FAULT_ADDR <= 32'h0;
        end
    end

endmodule
